// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback arbiter with register scoreboard for issue stalls
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  output logic        iss_stall,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        w_en,
  output logic [4:0]  w_adr,
  output logic [31:0] w_data,
  output logic [31:0] busy,
  output logic        err
);
  logic        last_b;
  logic        xfer, issue, wr;
  logic [4:0]  g_rd;
  logic [31:0] g_data, clr, set;
  always_comb begin
    a_ready   = rst_n && a_valid && (!b_valid || last_b);
    b_ready   = rst_n && b_valid && (!a_valid || !last_b);
    xfer      = a_ready || b_ready;
    g_rd      = a_ready ? a_rd : b_rd;
    g_data    = a_ready ? a_data : b_data;
    wr        = xfer && g_rd != 5'd0;
    iss_stall = rst_n && iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]);
    issue     = iss_valid && !iss_stall && iss_rd != 5'd0;
    clr       = wr ? 32'd1 << g_rd : '0;
    set       = issue ? 32'd1 << iss_rd : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy   <= '0;
      err    <= 1'b0;
      w_en   <= 1'b0;
      w_adr  <= '0;
      w_data <= '0;
      last_b <= 1'b1;
    end else begin
      busy <= (busy & ~clr) | set;
      err  <= err | (wr && !busy[g_rd]);
      w_en <= wr;
      if (xfer) begin
        w_adr  <= g_rd;
        w_data <= g_data;
        last_b <= b_ready;
      end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and random checks of rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;
  logic clk = 0, rst_n = 0;
  logic iss_valid = 0, a_valid = 0, b_valid = 0;
  logic [4:0] iss_rd = 0, iss_rs1 = 0, iss_rs2 = 0, a_rd = 0, b_rd = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic iss_stall, a_ready, b_ready, w_en, err;
  logic [4:0] w_adr;
  logic [31:0] w_data, busy;
  int tests = 0, fails = 0;
  bit [31:0] m_busy;
  bit m_err, m_wen, m_last_is_b, m_ga, m_gb;
  bit [4:0] m_wadr;
  bit [31:0] m_wdata;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_stall(iss_stall), .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .a_ready(a_ready), .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .w_en(w_en), .w_adr(w_adr), .w_data(w_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_wen = 0; m_wadr = 0; m_wdata = 0; m_last_is_b = 1;
    m_ga = 0; m_gb = 0;
  endtask

  task automatic idle();
    iss_valid = 0; a_valid = 0; b_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // One clock: compare everything at the negedge, then advance the model at the posedge.
  task automatic step();
    bit stall, ga, gb;
    bit [4:0] rd;
    bit [31:0] d;
    @(negedge clk);
    ga = a_valid && (!b_valid || m_last_is_b);
    gb = b_valid && !ga;
    stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("iss_stall", iss_stall, stall);
    chk("w_en", w_en, m_wen);
    chk("w_adr", w_adr, m_wadr);
    chk("w_data", w_data, m_wdata);
    chk("busy", busy, m_busy);
    chk("err", err, m_err);
    @(posedge clk);
    m_ga = ga; m_gb = gb;
    m_wen = 0;
    if (ga || gb) begin
      rd = ga ? a_rd : b_rd;
      d = ga ? a_data : b_data;
      m_wadr = rd; m_wdata = d; m_last_is_b = gb;
      if (rd != 0) begin
        if (!m_busy[rd]) m_err = 1;
        m_busy[rd] = 0;
        m_wen = 1;
      end
    end
    if (iss_valid && !stall && iss_rd != 0) m_busy[iss_rd] = 1;
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    iss_valid = 1; iss_rd = rd; iss_rs1 = 0; iss_rs2 = 0;
    step();
  endtask

  task automatic rand_run(input int n);
    bit hold_a, hold_b;
    for (int i = 0; i < n; i++) begin
      hold_a = a_valid && !m_ga;
      hold_b = b_valid && !m_gb;
      if (!hold_a) begin
        a_valid = ($urandom_range(0, 1) == 1);
        a_rd = 5'($urandom_range(0, 7));
        a_data = $urandom;
      end
      if (!hold_b) begin
        b_valid = ($urandom_range(0, 2) == 0);
        b_rd = 5'($urandom_range(0, 7));
        b_data = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd = 5'($urandom_range(0, 7));
      iss_rs1 = 5'($urandom_range(0, 7));
      iss_rs2 = 5'($urandom_range(0, 31));
      step();
    end
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_busy", busy, 32'h0);
    chk("reset_w_en", w_en, 1'b0);
    do_reset();

    // scoreboard set, stall, clear by writeback
    issue(5);
    chk("busy5_set", busy[5], 1'b1);
    iss_valid = 1; iss_rd = 1; iss_rs1 = 5; iss_rs2 = 0;
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    #1;
    chk("stall_rs1", iss_stall, 1'b1);
    step();
    chk("busy5_clr", busy[5], 1'b0);
    chk("wb_en", w_en, 1'b1);
    chk("wb_adr", w_adr, 5'd5);
    chk("wb_data", w_data, 32'hDEADBEEF);
    a_valid = 0;
    #1;
    chk("stall_gone", iss_stall, 1'b0);
    step();

    // round-robin under contention from reset
    do_reset();
    for (int r = 10; r <= 14; r++) issue(5'(r));
    idle();
    a_valid = 1; a_rd = 10; a_data = 32'hA0; b_valid = 1; b_rd = 11; b_data = 32'hB0;
    #1; chk("rr0_a", a_ready, 1'b1); step(); chk("rr0_wen", w_en, 1'b1); chk("rr0_adr", w_adr, 5'd10);
    a_rd = 12; a_data = 32'hA1;
    #1; chk("rr1_a", a_ready, 1'b0); step(); chk("rr1_wen", w_en, 1'b1); chk("rr1_adr", w_adr, 5'd11);
    b_rd = 13; b_data = 32'hB1;
    #1; chk("rr2_a", a_ready, 1'b1); step(); chk("rr2_wen", w_en, 1'b1); chk("rr2_adr", w_adr, 5'd12);
    a_rd = 14; a_data = 32'hA2;
    #1; chk("rr3_b", b_ready, 1'b1); step(); chk("rr3_wen", w_en, 1'b1); chk("rr3_adr", w_adr, 5'd13);
    idle();
    step();

    // write to x0 is accepted but not performed
    a_valid = 1; a_rd = 0; a_data = 32'h1234;
    #1; chk("x0_ready", a_ready, 1'b1);
    step();
    chk("x0_wen", w_en, 1'b0);
    chk("x0_err", err, 1'b0);

    // same-cycle issue and clear
    issue(7);
    iss_valid = 1; iss_rd = 3; iss_rs1 = 0; iss_rs2 = 0;
    a_valid = 1; a_rd = 7; a_data = 32'h77;
    step();
    chk("iss3_set", busy[3], 1'b1);
    chk("wb7_clr", busy[7], 1'b0);

    // write to a non-busy register flags a sticky error
    idle();
    b_valid = 1; b_rd = 9; b_data = 32'h99;
    step();
    chk("err_wen", w_en, 1'b1);
    chk("err_adr", w_adr, 5'd9);
    chk("err_set", err, 1'b1);
    idle();
    a_valid = 1; a_rd = 3; a_data = 32'h33;
    step();
    idle();
    step();
    chk("err_sticky", err, 1'b1);

    rand_run(3000);

    // asynchronous reset mid-cycle
    do_reset();
    issue(5); issue(7); issue(9);
    idle(); b_valid = 1; b_rd = 20; b_data = 32'h20;
    step();
    idle(); a_valid = 1; a_rd = 9; a_data = 32'h9;
    step();
    chk("pre_rst_busy", busy, 32'h0000_00A0);
    chk("pre_rst_wen", w_en, 1'b1);
    chk("pre_rst_err", err, 1'b1);
    a_valid = 1; b_valid = 1; iss_valid = 1; iss_rd = 5; iss_rs1 = 7; iss_rs2 = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst_busy", busy, 32'h0);
    chk("rst_wen", w_en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wadr", w_adr, 5'd0);
    chk("rst_wdata", w_data, 32'h0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_stall", iss_stall, 1'b0);
    do_reset();

    rand_run(2000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
